// File: rtl/dmem_responder_if.sv
// Load/store port between the CPU MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory with byte-enable stores and a programmable wait-state
// latency; one outstanding transaction, response held until the CPU accepts it.
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ADDR_W  = 8
) (
  input logic            clk,
  input logic            rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                ready_q;
  logic                valid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic                we_q;
  logic [31:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [LANES-1:0]    be_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept_c;
  logic                enter_resp_c;
  logic                cur_we_c;
  logic [31:0]         cur_addr_c;
  logic [DATA_W-1:0]   cur_wdata_c;
  logic [LANES-1:0]    cur_be_c;
  logic                err_c;
  logic [ADDR_W-1:0]   idx_c;
  logic                mem_we_c;
  logic [DATA_W-1:0]   rdata_c;

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // With zero latency the response is formed from the live request at the accept edge.
  always_comb begin
    accept_c     = (state == IDLE) && bus.req_valid && ready_q;
    enter_resp_c = (accept_c && (LATENCY == 0)) || ((state == WAIT) && (cnt == CNT_W'(1)));
    if (state == IDLE) begin
      cur_we_c    = bus.req_we;
      cur_addr_c  = bus.req_addr;
      cur_wdata_c = bus.req_wdata;
      cur_be_c    = bus.req_be;
    end else begin
      cur_we_c    = we_q;
      cur_addr_c  = addr_q;
      cur_wdata_c = wdata_q;
      cur_be_c    = be_q;
    end
    err_c    = (cur_addr_c[1:0] != 2'b00) || ((cur_addr_c >> (ADDR_W + 2)) != 32'd0);
    idx_c    = cur_addr_c[ADDR_W+1:2];
    mem_we_c = rst && enter_resp_c && cur_we_c && !err_c;
    rdata_c  = (cur_we_c || err_c) ? DATA_W'(0) : mem[idx_c];
  end

  // Array is deliberately left out of reset; only the write strobe sees it.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (cur_be_c[i]) mem[idx_c][8*i +: 8] <= cur_wdata_c[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
            cnt     <= CNT_W'(LATENCY);
            ready_q <= 1'b0;
            state   <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
      if (enter_resp_c) begin
        valid_q <= 1'b1;
        rdata_q <= rdata_c;
        err_q   <= err_c;
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the CPU's load/store port: the CPU's MEM stage initiates requests, and this block accepts them, applies a programmable wait-state latency, and returns read data or a write acknowledgement.
- Lets the pipelined RISC-V core be exercised against realistic multi-cycle memory, which in turn exercises its stall logic.
- Sits beside the CPU at top level.
- Contents are word-organised, with byte-enable writes.

Parameters:
- DEPTH, 256, number of 32-bit words; must be a power of two.
- LATENCY, 2, wait cycles inserted between request acceptance and response; legal range 0..15.
- ADDR_W, 8, word-index width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset; rst==0 at a rising edge resets the block.
- req_valid  in  1  CPU request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1=store, 0=load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables; bit i enables byte lane i (bits 8i+7:8i).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  CPU accepts response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  response is an error (misaligned or out of range).

Behaviour:
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Memory array is not cleared.
- Reset mid-operation: any pending transaction is dropped and a pending store is not written. The following cycle is IDLE.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept occurs when req_valid && req_ready at a rising edge. At accept, latch we/addr/wdata/be and load counter=LATENCY.
  - Next state is WAIT if LATENCY>0, otherwise RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle. When counter==1, next state is RESP.
- Entering RESP (same edge the state changes):
  - Error check: err = (addr[1:0]!=0) || (addr[31:ADDR_W+2]!=0). Word index = addr[ADDR_W+1:2].
  - Load: rsp_rdata = mem[index], or 0 if err.
  - Store: if !err, write each lane whose be bit is set; rsp_rdata = 0.
  - rsp_err = err. Erroneous stores write nothing.
- RESP:
  - rsp_valid=1 and req_ready=0.
  - rsp_rdata and rsp_err are held stable until handshake.
  - On rsp_valid && rsp_ready, next state is IDLE; rsp_valid, rsp_rdata and rsp_err clear to 0 on that edge.
- Latency: from the accept edge to the first cycle rsp_valid=1 is exactly LATENCY+1 cycles.
- Throughput: one outstanding transaction. The earliest next accept is the cycle after the response handshake (IDLE re-entered).
- No request pipelining: req_valid during WAIT or RESP is ignored. The CPU must hold its request until req_ready.
- be=0 store: completes normally with no byte changed and rsp_err=0.
- Read-after-write at the same address in consecutive transactions returns the newly written data.
- Address 0x0000_03FC with DEPTH=256 is the last valid word; 0x0000_0400 gives rsp_err=1.
- Misaligned check takes priority, but both error conditions set the same single bit.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, release -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Store/load, LATENCY=2:
  - Store addr=0x10, wdata=0xDEADBEEF, be=4'hF -> rsp_valid rises exactly 3 cycles after accept with rsp_err=0 and rdata=0.
  - Load addr=0x10 -> rdata=0xDEADBEEF.
- Byte enables: after the previous store, store addr=0x10, wdata=0x000000AA, be=4'b0001 -> a load returns 0xDEADBEAA. A be=0 store leaves the word unchanged.
- Errors:
  - Load addr=0x12 -> rsp_err=1, rdata=0.
  - Store addr=0x400, wdata=0x12345678 -> rsp_err=1. A later load of 0x0 returns its prior value, unaffected.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rdata stay stable and req_ready=0. A new req_valid in this window is not accepted. Raise rsp_ready -> IDLE next cycle and the new request is accepted.
- LATENCY=0 and mid-operation reset:
  - With LATENCY=0, rsp_valid appears 1 cycle after accept.
  - Assert rst=0 during WAIT of a store to 0x20 -> after reset, a load of 0x20 returns the old value and rsp_valid was never asserted for the aborted store.
